instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the RISC-V pipeline. It owns the program counter, presents it to the instruction cache, and drives cache page refills on a miss. It handles branch/jump redirects and passes `{pc, instruction}` pairs to decode over a valid/ready handshake. It sits between the branch-resolution logic and the decoder, with the instruction cache beside it.

## Interface
Parameters:
- `RESET_PC`, 64'h0: PC value loaded on reset.
- `PAGE_BITS`, 12: byte-offset width of one cache page; the refill address is `pc[63:PAGE_BITS]`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icache_pc`  out  64  current PC, driven combinationally from the PC register.
- `icache_r`  in  1  cache hit for `icache_pc`, same cycle.
- `icache_instr`  in  32  instruction word at `icache_pc`; valid only when `icache_r`=1.
- `refill_req`  out  1  page refill request; level signal.
- `refill_addr`  out  64-PAGE_BITS  page number to fill; latched.
- `refill_done`  in  1  one-cycle pulse; the page is now resident.
- `redirect_valid`  in  1  redirect request, one cycle.
- `redirect_pc`  in  64  redirect target.
- `dec_valid`  out  1  decode output register holds an instruction.
- `dec_ready`  in  1  decoder accepts this cycle.
- `dec_pc`  out  64  PC of `dec_instr`.
- `dec_instr`  out  32  instruction to decode.
- `fetch_fault`  out  1  misaligned redirect target; sticky until the next redirect.
- `perf_fetches`  out  32  instructions delivered (see Configuration).
- `perf_miss_cycles`  out  32  cycles spent in MISS (see Configuration).

## Operation
States: FETCH, MISS, FAULT.
- Reset values:
  - pc=RESET_PC, state=FETCH.
  - dec_valid=0, dec_pc=0, dec_instr=32'h00000013 (NOP).
  - refill_req=0, refill_addr=0, fetch_fault=0, perf counters=0.
- "slot free" means `!dec_valid || dec_ready`.
- FETCH:
  - If `icache_r` and slot free: load dec_pc=pc and dec_instr=icache_instr, set dec_valid=1, pc=pc+4.
  - If `icache_r` and slot not free: hold everything.
  - If `!icache_r`: refill_addr=pc[63:PAGE_BITS], refill_req=1, go to MISS.
  - If slot free and no delivery this cycle: dec_valid=0.
- MISS:
  - refill_req stays 1 and refill_addr stays stable until `refill_done`.
  - On `refill_done`: refill_req=0, go to FETCH. The cache hit is re-evaluated next cycle.
  - The decode output drains normally (dec_ready clears dec_valid).
- FAULT:
  - No fetch and no refill; dec_valid drains to 0.
  - Leaves only on a redirect.
- Redirect (any state), highest priority:
  - pc=redirect_pc, dec_valid=0. A simultaneous dec_ready handshake is discarded.
  - If redirect_pc[1:0]≠0: fetch_fault=1, state=FAULT. From MISS, the pending refill is first completed silently; the move to FAULT happens at `refill_done`.
  - Otherwise fetch_fault=0. Next state is FETCH, or stays MISS if a refill is pending.
  - The pending refill is never aborted; refill_addr is not changed by a redirect.
- Arithmetic: pc+4 is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Crossing a page boundary (pc[11:0]=FFC → 000 for PAGE_BITS=12) causes a miss on the new page when it is not resident.

## Timing
- Hit latency: icache_r=1 in cycle n → dec_valid=1 in cycle n+1.
- Throughput: one instruction per cycle while hitting and dec_ready=1.
- Miss: icache_r=0 in cycle n → refill_req=1 in cycle n+1.
- Refill: refill_done in cycle m → refill_req=0 and state=FETCH in cycle m+1 → earliest dec_valid in cycle m+2.
- Redirect in cycle n → icache_pc=redirect_pc in cycle n+1; dec_valid=0 in cycle n+1.
- Redirect and refill_done in the same cycle: both take effect; the state follows the redirect rules.
- An rst_n assertion mid-refill drops refill_req immediately. The memory bus side must tolerate a dropped request.

## Configuration
- `FETCH_PERF_EN` defined:
  - perf_fetches increments on every dec_valid load.
  - perf_miss_cycles increments on every cycle spent in MISS.
  - Both counters are 32-bit, wrap at 2^32, and reset to 0.
- `FETCH_PERF_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t` {FETCH, MISS, FAULT}.
  - `XLEN`=64, `ILEN`=32, `NOP_INSTR`=32'h00000013.
- Sub-module `fetch_perf_counters` holds both counters; instantiated only under `FETCH_PERF_EN`.

## Test plan
- Reset with RESET_PC=64'h1000, icache_r=1, dec_ready=1 → dec_pc sequence 1000, 1004, 1008 on consecutive cycles; fetch_fault=0.
- icache_r=0 at pc=64'h2FFC → refill_req=1 with refill_addr=52'h2 one cycle later. Hold refill_done low 5 cycles, then pulse it → perf_miss_cycles≥5 (with `FETCH_PERF_EN`); dec_pc=2FFC two cycles after the pulse.
- dec_ready=0 for 3 cycles while hitting → dec_valid, dec_pc and pc frozen; no instruction lost or duplicated after release.
- Redirect to 64'h8000 in the same cycle as dec_ready=1 → dec_valid=0 next cycle, icache_pc=8000; the stale instruction is never delivered.
- Redirect to 64'h8002 → fetch_fault=1, no further dec_valid. A later redirect to 64'h8004 → fetch_fault=0 and fetch resumes at 8004.
- Redirect during MISS with refill_done in the same cycle → refill_req drops and fetch resumes at the redirect target; refill_addr is unchanged until the next miss.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch controller state (FETCH, MISS, FAULT)
//   XLEN          : architectural address width
//   ILEN          : instruction word width
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0)
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// ---------------------------------------------------------------------------
// fetch_perf_counters
// Free-running 32-bit event counters for the fetch stage. Both wrap at 2^32.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   fetch_inc      : an instruction was loaded into the decode register
//   miss_inc       : the fetch controller spent this cycle in MISS
//   fetches        : count of fetch_inc cycles
//   miss_cycles    : count of miss_inc cycles
// ---------------------------------------------------------------------------
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        miss_inc,
    output logic [31:0] fetches,
    output logic [31:0] miss_cycles
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetches     <= '0;
            miss_cycles <= '0;
        end else begin
            if (fetch_inc) fetches     <= fetches + 32'd1;
            if (miss_inc)  miss_cycles <= miss_cycles + 32'd1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the PC, looks it up in the instruction cache, requests
// page refills on a miss, applies branch/jump redirects and hands
// {pc, instruction} pairs to decode over a valid/ready handshake.
//
// Optional build macro: FETCH_PERF_EN
//   defined   : perf_fetches / perf_miss_cycles are live 32-bit counters
//   undefined : both perf ports are tied to zero, no counter flops
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   icache_pc         : current PC presented to the cache
//   icache_r          : cache hit for icache_pc (same cycle)
//   icache_instr      : instruction word at icache_pc
//   refill_req        : page refill request (level, high while in MISS)
//   refill_addr       : page number being refilled (pc[63:PAGE_BITS])
//   refill_done       : one-cycle pulse, page now resident
//   redirect_valid/pc : redirect request and target
//   dec_valid/ready   : decode handshake
//   dec_pc/dec_instr  : instruction handed to decode and its PC
//   fetch_fault       : misaligned redirect target, sticky until next redirect
//   perf_fetches      : instructions delivered
//   perf_miss_cycles  : cycles spent in MISS
// ---------------------------------------------------------------------------
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          PAGE_BITS = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [XLEN-1:0]           icache_pc,
    input  logic                      icache_r,
    input  logic [ILEN-1:0]           icache_instr,
    output logic                      refill_req,
    output logic [XLEN-PAGE_BITS-1:0] refill_addr,
    input  logic                      refill_done,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [XLEN-1:0]           dec_pc,
    output logic [ILEN-1:0]           dec_instr,
    output logic                      fetch_fault,
    output logic [31:0]               perf_fetches,
    output logic [31:0]               perf_miss_cycles
);

    fetch_state_t              state_q, state_n;
    logic [XLEN-1:0]           pc_p0, pc_n;
    logic                      vld_p1, vld_n;
    logic [XLEN-1:0]           dec_pc_p1, dec_pc_n;
    logic [ILEN-1:0]           dec_instr_p1, dec_instr_n;
    logic [XLEN-PAGE_BITS-1:0] refill_addr_q, refill_addr_n;
    logic                      fault_q, fault_n;
    // A misaligned redirect taken while a refill is outstanding; the move to
    // FAULT is deferred until the refill completes.
    logic                      fault_pend_q, fault_pend_n;
    logic                      slot_free;

    assign slot_free = !vld_p1 || dec_ready;

    // Stage 0 -> stage 1 boundary: PC register feeds the cache, decode
    // register captures the hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_p0         <= RESET_PC;
            vld_p1        <= 1'b0;
            dec_pc_p1     <= '0;
            dec_instr_p1  <= NOP_INSTR;
            refill_addr_q <= '0;
            fault_q       <= 1'b0;
            fault_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_n;
            pc_p0         <= pc_n;
            vld_p1        <= vld_n;
            dec_pc_p1     <= dec_pc_n;
            dec_instr_p1  <= dec_instr_n;
            refill_addr_q <= refill_addr_n;
            fault_q       <= fault_n;
            fault_pend_q  <= fault_pend_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        pc_n          = pc_p0;
        vld_n         = vld_p1;
        dec_pc_n      = dec_pc_p1;
        dec_instr_n   = dec_instr_p1;
        refill_addr_n = refill_addr_q;
        fault_n       = fault_q;
        fault_pend_n  = fault_pend_q;

        if (redirect_valid) begin
            // Redirect wins over everything; any handshake this cycle is
            // dropped and an outstanding refill keeps running to completion.
            pc_n  = redirect_pc;
            vld_n = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_n = 1'b1;
                if (state_q == MISS && !refill_done) begin
                    state_n      = MISS;
                    fault_pend_n = 1'b1;
                end else begin
                    state_n      = FAULT;
                    fault_pend_n = 1'b0;
                end
            end else begin
                fault_n      = 1'b0;
                fault_pend_n = 1'b0;
                state_n      = (state_q == MISS && !refill_done) ? MISS : FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (icache_r) begin
                        if (slot_free) begin
                            vld_n       = 1'b1;
                            dec_pc_n    = pc_p0;
                            dec_instr_n = icache_instr;
                            pc_n        = pc_p0 + 64'd4;
                        end
                    end else begin
                        refill_addr_n = pc_p0[XLEN-1:PAGE_BITS];
                        state_n       = MISS;
                        if (slot_free) vld_n = 1'b0;
                    end
                end
                MISS: begin
                    if (slot_free) vld_n = 1'b0;
                    if (refill_done) begin
                        state_n      = fault_pend_q ? FAULT : FETCH;
                        fault_pend_n = 1'b0;
                    end
                end
                FAULT: begin
                    if (slot_free) vld_n = 1'b0;
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    assign icache_pc   = pc_p0;
    // Derived from state so an asynchronous reset drops it at once.
    assign refill_req  = (state_q == MISS);
    assign refill_addr = refill_addr_q;
    assign dec_valid   = vld_p1;
    assign dec_pc      = dec_pc_p1;
    assign dec_instr   = dec_instr_p1;
    assign fetch_fault = fault_q;

`ifdef FETCH_PERF_EN
    logic fetch_load;
    assign fetch_load = (state_q == FETCH) && !redirect_valid && icache_r && slot_free;

    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_inc   (fetch_load),
        .miss_inc    (state_q == MISS),
        .fetches     (perf_fetches),
        .miss_cycles (perf_miss_cycles)
    );
`else
    assign perf_fetches     = '0;
    assign perf_miss_cycles = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] icache_pc;
    logic        icache_r;
    logic [31:0] icache_instr;
    logic        refill_req;
    logic [51:0] refill_addr;
    logic        refill_done;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [63:0] dec_pc;
    logic [31:0] dec_instr;
    logic        fetch_fault;
    logic [31:0] perf_fetches;
    logic [31:0] perf_miss_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Cache data model: instruction word is a fixed scramble of its address.
    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0003;
    endfunction
    assign icache_instr = instr_of(icache_pc);

    instruction_fetch #(.RESET_PC(64'h1000), .PAGE_BITS(12)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .icache_pc        (icache_pc),
        .icache_r         (icache_r),
        .icache_instr     (icache_instr),
        .refill_req       (refill_req),
        .refill_addr      (refill_addr),
        .refill_done      (refill_done),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .dec_valid        (dec_valid),
        .dec_ready        (dec_ready),
        .dec_pc           (dec_pc),
        .dec_instr        (dec_instr),
        .fetch_fault      (fetch_fault),
        .perf_fetches     (perf_fetches),
        .perf_miss_cycles (perf_miss_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_fetches;
        logic [31:0] exp_miss;
        rst_n          = 1'b0;
        icache_r       = 1'b1;
        dec_ready      = 1'b1;
        refill_done    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick(); tick();

        // Reset state
        chk("rst_pc",        icache_pc, 64'h1000);
        chk("rst_dec_valid", {63'd0, dec_valid}, 64'd0);
        chk("rst_dec_pc",    dec_pc, 64'd0);
        chk("rst_dec_instr", {32'd0, dec_instr}, 64'h13);
        chk("rst_refill_req",{63'd0, refill_req}, 64'd0);
        chk("rst_refill_addr",{12'd0, refill_addr}, 64'd0);
        chk("rst_fault",     {63'd0, fetch_fault}, 64'd0);
        chk("rst_perf_f",    {32'd0, perf_fetches}, 64'd0);
        chk("rst_perf_m",    {32'd0, perf_miss_cycles}, 64'd0);

        rst_n = 1'b1;
        // Streaming hits: 1000, 1004, 1008
        tick();
        chk("s0_valid", {63'd0, dec_valid}, 64'd1);
        chk("s0_pc",    dec_pc, 64'h1000);
        chk("s0_instr", {32'd0, dec_instr}, 64'h5A5A_1003);
        tick();
        chk("s1_pc",    dec_pc, 64'h1004);
        tick();
        chk("s2_pc",    dec_pc, 64'h1008);
        chk("s2_fault", {63'd0, fetch_fault}, 64'd0);

        // Back-pressure for 3 cycles
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {63'd0, dec_valid}, 64'd1);
            chk("bp_decpc", dec_pc, 64'h1008);
            chk("bp_pc",    icache_pc, 64'h100C);
        end
        dec_ready = 1'b1;
        tick();
        chk("rel0_pc", dec_pc, 64'h100C);
        tick();
        chk("rel1_pc", dec_pc, 64'h1010);

        // Miss at 2FFC
        redirect_valid = 1'b1; redirect_pc = 64'h2FFC;
        tick();
        redirect_valid = 1'b0;
        chk("rd_2ffc_valid", {63'd0, dec_valid}, 64'd0);
        chk("rd_2ffc_pc",    icache_pc, 64'h2FFC);
        icache_r = 1'b0;
        tick();
        chk("miss_req",   {63'd0, refill_req}, 64'd1);
        chk("miss_addr",  {12'd0, refill_addr}, 64'h2);
        chk("miss_valid", {63'd0, dec_valid}, 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("miss_hold_req",  {63'd0, refill_req}, 64'd1);
        chk("miss_hold_addr", {12'd0, refill_addr}, 64'h2);
        refill_done = 1'b1; icache_r = 1'b1;
        tick();
        refill_done = 1'b0;
        chk("done_req",   {63'd0, refill_req}, 64'd0);
        chk("done_valid", {63'd0, dec_valid}, 64'd0);
`ifdef FETCH_PERF_EN
        exp_miss = 32'd6;
`else
        exp_miss = 32'd0;
`endif
        chk("perf_miss1", {32'd0, perf_miss_cycles}, {32'd0, exp_miss});
        tick();
        chk("refetch_valid", {63'd0, dec_valid}, 64'd1);
        chk("refetch_pc",    dec_pc, 64'h2FFC);
        chk("page_cross_pc", icache_pc, 64'h3000);

        // Page-crossing miss, then redirect + refill_done together
        icache_r = 1'b0;
        tick();
        chk("pc_miss_req",  {63'd0, refill_req}, 64'd1);
        chk("pc_miss_addr", {12'd0, refill_addr}, 64'h3);
        redirect_valid = 1'b1; redirect_pc = 64'h5000; refill_done = 1'b1; icache_r = 1'b1;
        tick();
        redirect_valid = 1'b0; refill_done = 1'b0;
        chk("rdd_req",   {63'd0, refill_req}, 64'd0);
        chk("rdd_pc",    icache_pc, 64'h5000);
        chk("rdd_addr",  {12'd0, refill_addr}, 64'h3);
        chk("rdd_valid", {63'd0, dec_valid}, 64'd0);
        tick();
        chk("rdd_fetch", dec_pc, 64'h5000);

        // Redirect coinciding with a handshake
        redirect_valid = 1'b1; redirect_pc = 64'h8000;
        tick();
        redirect_valid = 1'b0;
        chk("rh_valid", {63'd0, dec_valid}, 64'd0);
        chk("rh_pc",    icache_pc, 64'h8000);
        tick();
        chk("rh_next_valid", {63'd0, dec_valid}, 64'd1);
        chk("rh_next_pc",    dec_pc, 64'h8000);

        // Misaligned redirect -> FAULT
        redirect_valid = 1'b1; redirect_pc = 64'h8002;
        tick();
        redirect_valid = 1'b0;
        chk("flt_fault", {63'd0, fetch_fault}, 64'd1);
        chk("flt_valid", {63'd0, dec_valid}, 64'd0);
        tick(); tick();
        chk("flt_hold_valid", {63'd0, dec_valid}, 64'd0);
        chk("flt_hold_fault", {63'd0, fetch_fault}, 64'd1);
        chk("flt_no_refill",  {63'd0, refill_req}, 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h8004;
        tick();
        redirect_valid = 1'b0;
        chk("unflt_fault", {63'd0, fetch_fault}, 64'd0);
        chk("unflt_pc",    icache_pc, 64'h8004);
        tick();
        chk("unflt_valid", {63'd0, dec_valid}, 64'd1);
        chk("unflt_decpc", dec_pc, 64'h8004);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_decpc", dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc",    icache_pc, 64'h0);

        // Miss at 0, then asynchronous reset mid-refill
        icache_r = 1'b0;
        tick();
        chk("m0_req",  {63'd0, refill_req}, 64'd1);
        chk("m0_addr", {12'd0, refill_addr}, 64'h0);
`ifdef FETCH_PERF_EN
        exp_fetches = 32'd10;
        exp_miss    = 32'd7;
`else
        exp_fetches = 32'd0;
        exp_miss    = 32'd0;
`endif
        chk("perf_fetches", {32'd0, perf_fetches}, {32'd0, exp_fetches});
        chk("perf_miss2",   {32'd0, perf_miss_cycles}, {32'd0, exp_miss});
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   {63'd0, refill_req}, 64'd0);
        chk("arst_pc",    icache_pc, 64'h1000);
        chk("arst_valid", {63'd0, dec_valid}, 64'd0);
        chk("arst_perf",  {32'd0, perf_fetches}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
